// File: rtl/cpu_mem_reader.sv
// cpu_mem_reader: streams one length-prefixed CPU-memory packet to the UPDI frame builder.
// Define PKT_XOR_CHECK_EN to read and verify an XOR trailer byte after the payload.
module cpu_mem_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_LEN = 64
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            pkt_len,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last
);
  typedef enum logic [3:0] {IDLE, HDR_REQ, HDR_WAIT, DAT_REQ, DAT_WAIT, OUT, CHK_REQ, CHK_WAIT, DONE} state_t;
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
`ifdef PKT_XOR_CHECK_EN
  localparam state_t FINAL = CHK_REQ;
`else
  localparam state_t FINAL = DONE;
`endif
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic err_q, err_d;
  logic is_last, bad_len;
`ifdef PKT_XOR_CHECK_EN
  logic [DATA_WIDTH-1:0] x_q, x_d;
`endif
  assign is_last = cnt_q == len_q;
  assign bad_len = (8'(mem_dout0) == 8'd0) || (8'(mem_dout0) > MAX_L);
  always_ff @(posedge clk0) begin
    if (rst0) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk0) begin
    if (rst0) begin
      addr_q <= '0;
      data_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef PKT_XOR_CHECK_EN
      x_q <= '0;
`endif
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
`ifdef PKT_XOR_CHECK_EN
      x_q <= x_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
`ifdef PKT_XOR_CHECK_EN
    x_d = x_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR_REQ;
        addr_d = start_addr;
      end
      HDR_REQ: state_d = HDR_WAIT;
      HDR_WAIT: begin
        len_d = 8'(mem_dout0);
        cnt_d = '0;
        err_d = bad_len;
        addr_d = addr_q + ONE;
        state_d = bad_len ? DONE : DAT_REQ;
`ifdef PKT_XOR_CHECK_EN
        x_d = '0;
`endif
      end
      DAT_REQ: state_d = DAT_WAIT;
      DAT_WAIT: begin
        data_d = mem_dout0;
        cnt_d = cnt_q + 8'd1;
        state_d = OUT;
`ifdef PKT_XOR_CHECK_EN
        x_d = x_q ^ mem_dout0;
`endif
      end
      OUT: if (tx_ready) begin
        addr_d = addr_q + ONE;
        state_d = is_last ? FINAL : DAT_REQ;
      end
`ifdef PKT_XOR_CHECK_EN
      CHK_REQ: state_d = CHK_WAIT;
      CHK_WAIT: begin
        err_d = mem_dout0 != x_q;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = (state_q != IDLE) && (state_q != DONE);
    done = state_q == DONE;
    err = done && err_q;
    pkt_len = len_q;
    mem_csb0 = !(state_q inside {HDR_REQ, DAT_REQ, CHK_REQ});
    mem_web0 = 1'b1;
    mem_addr0 = addr_q;
    tx_data = data_q;
    tx_valid = state_q == OUT;
    tx_last = tx_valid && is_last;
  end
endmodule

// File: doc/cpu_mem_reader.md
# cpu_mem_reader

Reads one packet that the CPU has loaded into CPU memory and streams its payload bytes to the UPDI command-frame builder over a valid/ready byte interface. Sits between the CPU memory's single read/write port (driven here in read-only mode) and the frame builder. Each packet is stored as a length byte followed by that many payload bytes, starting at a CPU-supplied address.

## Interface
- DATA_WIDTH, 8, memory word and stream byte width
- ADDR_WIDTH, 7, memory address width (128 words)
- MAX_LEN, 64, largest legal payload length
- clk0  in  1  clock, all logic on rising edge
- rst0  in  1  reset, synchronous, active-high
- start  in  1  packet request, sampled only in IDLE
- start_addr  in  ADDR_WIDTH  address of the packet's length byte
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at packet end
- err  out  1  valid only with done: bad length or checksum mismatch
- pkt_len  out  8  latched length byte
- mem_csb0  out  1  memory chip select, active low
- mem_web0  out  1  memory write enable, active low; tied 1
- mem_addr0  out  ADDR_WIDTH  memory address
- mem_dout0  in  DATA_WIDTH  memory read data
- tx_data  out  DATA_WIDTH  payload byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  frame builder accepts byte
- tx_last  out  1  marks final payload byte, qualified by tx_valid

## Operation
- FSM states: IDLE, HDR_REQ, HDR_WAIT, DAT_REQ, DAT_WAIT, OUT, (CHK_REQ, CHK_WAIT when configured), DONE.
- Reset values: busy=0, done=0, err=0, pkt_len=0, mem_csb0=1, mem_web0=1, mem_addr0=0, tx_data=0, tx_valid=0, tx_last=0; state IDLE.
- IDLE + start=1 -> HDR_REQ with mem_addr0=start_addr. start in any other state is ignored.
- *_REQ: mem_csb0=0 for exactly one cycle. *_WAIT: mem_csb0=1. mem_dout0 is captured on the rising edge that ends *_WAIT.
- Header capture: len = mem_dout0. If len==0 or len>MAX_LEN -> DONE with err=1; nothing is forwarded. Otherwise -> DAT_REQ at the next address.
- DAT_WAIT -> OUT: tx_data=captured byte, tx_valid=1, and tx_last=1 if it is byte number len.
- OUT holds tx_data, tx_valid and tx_last stable until tx_valid&tx_ready. Then the block goes to DAT_REQ, or to DONE after the last byte (CHK_REQ when configured).
- Address increments by 1 modulo 2^ADDR_WIDTH; 0x7F wraps to 0x00.
- DONE lasts one cycle: done=1, busy=0 in that same cycle, then IDLE.
- rst0 in any state forces reset values on the next edge; a partially sent packet is abandoned and tx_valid drops.

## Timing
- Memory read latency: address issued in REQ cycle, data sampled 2 edges after REQ is entered.
- start sampled at edge E0. HDR_REQ follows E0, header is captured at E2, and the first tx_valid rises after E4.
- With tx_ready held high: one payload byte per 3 cycles.
- Without the configured feature, done is high in the cycle right after the last handshake edge.
- With the configured feature, done is high 2 cycles later, after the trailer capture.
- Bad length: done=err=1 in the cycle right after E2.

## Configuration
- Macro PKT_XOR_CHECK_EN.
- Defined: a trailer byte follows the payload and holds the XOR of all payload bytes. It is read via CHK_REQ/CHK_WAIT and is not forwarded. err=1 with done on mismatch.
- Undefined: there is no trailer read, and err is raised only for a bad length.

## Test plan
- mem[0x10..0x13]=03,55,A5,01, start_addr=0x10, tx_ready=1 -> tx bytes 55,A5,01; tx_last only on 01; first tx_valid 4 cycles after start; done one cycle; err=0.
- Same packet, tx_ready low for 5 cycles while tx_valid=1 -> tx_data/tx_last stable; no extra memory reads; bytes neither lost nor repeated.
- start_addr=0x7E, mem[0x7E]=02, mem[0x7F]=11, mem[0x00]=22 -> bytes 11,22; mem_addr0 wraps 7F->00.
- Length byte 0x00, then length byte 0x41 (MAX_LEN=64) -> done=err=1, tx_valid never asserted; start pulses during busy are ignored.
- rst0 asserted while second byte is in OUT -> next cycle all outputs at reset values; a fresh start then delivers the full packet.
- PKT_XOR_CHECK_EN defined, packet 02,0F,F0,FF -> err=0; trailer changed to 00 -> err=1; trailer never appears on tx_data.
